axi_sts_register: RTL and testbench

AXI4-Lite read-only status register bank. It is the PL-to-PS counterpart of the config register block: it exposes a wide status bus `sts_data` to the processor as consecutive 32-bit words. Reading word 0 takes a coherent snapshot of the whole bus, so multi-word values read back consistently. It sits on the same AXI-Lite interconnect and is driven by the same master model in benches.

---
 rtl/axi_sts_pkg.sv | 14 +
 rtl/axi_sts_register_if.sv | 37 +++
 rtl/axi_sts_wr_sink.sv | 56 +++++
 rtl/axi_sts_register.sv | 109 ++++++++++
 tb/tb_axi_sts_register.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sts_pkg.sv
// rtl/axi_sts_pkg.sv - shared constants and types for the AXI-Lite status register bank
package axi_sts_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_LSB = 2;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_sts_register_if.sv
// rtl/axi_sts_register_if.sv - AXI4-Lite slave bus bundle with master/slave views
interface axi_sts_register_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_sts_wr_sink.sv
// rtl/axi_sts_wr_sink.sv - AW/W/B responder that answers every write with SLVERR
module axi_sts_wr_sink
    import axi_sts_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_awvalid,
    output logic       o_awready,
    input  logic       i_wvalid,
    output logic       o_wready,
    output logic       o_bvalid,
    output logic [1:0] o_bresp,
    input  logic       i_bready
);
    logic       r_active;
    logic       r_aw_seen;
    logic       r_w_seen;
    logic       r_bvalid;
    logic [1:0] r_bresp;
    logic       w_aw_hs;
    logic       w_w_hs;

    // r_active keeps the readys low until the first edge after reset releases
    assign o_awready = r_active && !r_aw_seen && !r_bvalid;
    assign o_wready  = r_active && !r_w_seen && !r_bvalid;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    assign w_aw_hs = i_awvalid && o_awready;
    assign w_w_hs  = i_wvalid && o_wready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_aw_seen <= 1'b0;
            r_w_seen  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_active <= 1'b1;
            if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
            if ((r_aw_seen || w_aw_hs) && (r_w_seen || w_w_hs)) begin
                r_bvalid  <= 1'b1;
                r_bresp   <= RESP_SLVERR;
                r_aw_seen <= 1'b0;
                r_w_seen  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_seen <= 1'b1;
                if (w_w_hs)  r_w_seen  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_sts_register.sv
// rtl/axi_sts_register.sv - read-only AXI4-Lite window onto a wide status bus with word-0 snapshot
module axi_sts_register
    import axi_sts_pkg::*;
#(
    parameter int STS_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int SNAPSHOT       = 1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [STS_DATA_WIDTH-1:0] sts_data,
    axi_sts_register_if.slave         s_axi
);
    localparam int N = STS_DATA_WIDTH / AXI_DATA_WIDTH;
    // One index bit beyond the bank so the window just above it answers SLVERR instead of aliasing
    localparam int IDX_W = $clog2(N) + 1;
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N);

    rd_state_t                 r_state;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic [STS_DATA_WIDTH-1:0] r_snap;

    logic [IDX_W-1:0]          w_idx;
    logic                      w_in_range;
    logic [AXI_DATA_WIDTH-1:0] w_word;
    logic                      w_unused;

    assign w_idx      = s_axi.s_axi_araddr[ADDR_LSB +: IDX_W];
    assign w_in_range = (w_idx < N_IDX);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == IDX_W'(i)) begin
                if (SNAPSHOT != 0 && i != 0) begin
                    w_word = r_snap[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                end else begin
                    w_word = sts_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_snap    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (s_axi.s_axi_arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= R_DATA;
                        if (w_in_range) begin
                            r_rdata <= w_word;
                            r_rresp <= RESP_OKAY;
                            if (SNAPSHOT != 0 && w_idx == '0) begin
                                r_snap <= sts_data;
                            end
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_SLVERR;
                        end
                    end
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;

    axi_sts_wr_sink u_wr_sink (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_awvalid (s_axi.s_axi_awvalid),
        .o_awready (s_axi.s_axi_awready),
        .i_wvalid  (s_axi.s_axi_wvalid),
        .o_wready  (s_axi.s_axi_wready),
        .o_bvalid  (s_axi.s_axi_bvalid),
        .o_bresp   (s_axi.s_axi_bresp),
        .i_bready  (s_axi.s_axi_bready)
    );

    // Write payload and upper read-address bits carry no meaning for a read-only bank
    assign w_unused = ^{s_axi.s_axi_awaddr, s_axi.s_axi_wdata, s_axi.s_axi_wstrb,
                        s_axi.s_axi_araddr};

endmodule

// File: tb/tb_axi_sts_register.sv
// tb/tb_axi_sts_register.sv - directed self-checking bench for axi_sts_register
module tb_axi_sts_register;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] sts = 64'h0;

    logic        sel = 1'b0;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = 32'h0;
    logic        rready = 1'b0;
    logic        awvalid = 1'b0;
    logic [31:0] awaddr = 32'h0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        bready = 1'b1;

    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    int n_cmp = 0;
    int n_bad = 0;
    int bcnt = 0;
    logic [1:0] blast = 2'b00;

    always #5 aclk = ~aclk;

    axi_sts_register_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus0 ();
    axi_sts_register_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus1 ();

    axi_sts_register #(.STS_DATA_WIDTH(64), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .SNAPSHOT(1)) dut (
        .aclk(aclk), .areset(areset), .sts_data(sts), .s_axi(bus0)
    );
    axi_sts_register #(.STS_DATA_WIDTH(64), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .SNAPSHOT(0)) dut_live (
        .aclk(aclk), .areset(areset), .sts_data(sts), .s_axi(bus1)
    );

    assign bus0.s_axi_arvalid = arvalid & ~sel;
    assign bus1.s_axi_arvalid = arvalid & sel;
    assign bus0.s_axi_araddr  = araddr;
    assign bus1.s_axi_araddr  = araddr;
    assign bus0.s_axi_rready  = rready & ~sel;
    assign bus1.s_axi_rready  = rready & sel;
    assign bus0.s_axi_awvalid = awvalid;
    assign bus0.s_axi_awaddr  = awaddr;
    assign bus0.s_axi_wvalid  = wvalid;
    assign bus0.s_axi_wdata   = wdata;
    assign bus0.s_axi_wstrb   = 4'hF;
    assign bus0.s_axi_bready  = bready;
    assign bus1.s_axi_awvalid = 1'b0;
    assign bus1.s_axi_awaddr  = 32'h0;
    assign bus1.s_axi_wvalid  = 1'b0;
    assign bus1.s_axi_wdata   = 32'h0;
    assign bus1.s_axi_wstrb   = 4'h0;
    assign bus1.s_axi_bready  = 1'b1;

    assign m_arready = sel ? bus1.s_axi_arready : bus0.s_axi_arready;
    assign m_rvalid  = sel ? bus1.s_axi_rvalid  : bus0.s_axi_rvalid;
    assign m_rdata   = sel ? bus1.s_axi_rdata   : bus0.s_axi_rdata;
    assign m_rresp   = sel ? bus1.s_axi_rresp   : bus0.s_axi_rresp;

    task automatic wait_arready(output logic ok);
        int n;
        n = 0;
        while (m_arready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        ok = (m_arready === 1'b1);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL arready_timeout: arready=%b after %0d cycles, required 1", m_arready, n);
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                      output logic lat_ok);
        logic ok;
        data = '0;
        resp = '0;
        lat_ok = 1'b0;
        @(negedge aclk);
        araddr = addr;
        arvalid = 1'b1;
        wait_arready(ok);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        lat_ok = (m_rvalid === 1'b1);
        data = m_rdata;
        resp = m_rresp;
        rready = 1'b1;
        @(posedge aclk);
        #1;
        rready = 1'b0;
    endtask

    task automatic tick();
        @(negedge aclk);
        if (bus0.s_axi_bvalid === 1'b1) begin
            bcnt++;
            blast = bus0.s_axi_bresp;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_cmp++;
        if ({bus0.s_axi_arready, bus0.s_axi_awready, bus0.s_axi_wready, bus0.s_axi_rvalid, bus0.s_axi_bvalid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ar/aw/w/rv/bv=%b, required 00000",
                     {bus0.s_axi_arready, bus0.s_axi_awready, bus0.s_axi_wready, bus0.s_axi_rvalid, bus0.s_axi_bvalid});
        end
        n_cmp++;
        if ({bus0.s_axi_rdata, bus0.s_axi_rresp, bus0.s_axi_bresp} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b, required 0", bus0.s_axi_rdata, bus0.s_axi_rresp, bus0.s_axi_bresp);
        end
        areset = 1'b0;
        #1;
        n_cmp++;
        if (bus0.s_axi_arready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_before_edge: arready=%b, required 0", bus0.s_axi_arready);
        end
        @(posedge aclk);
        #1;
        n_cmp++;
        if ({bus0.s_axi_arready, bus0.s_axi_awready, bus0.s_axi_wready} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_first_edge_ready: ar/aw/w=%b, required 111",
                     {bus0.s_axi_arready, bus0.s_axi_awready, bus0.s_axi_wready});
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] d;
        logic [1:0]  r;
        logic        lat;
        sel = 1'b0;
        sts = 64'h11223344_55667788;
        rd(32'h00, d, r, lat);
        n_cmp++;
        if (d !== 32'h55667788 || r !== 2'b00 || lat !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_rd0: rdata=%h rresp=%b lat1=%b, required 55667788 00 1", d, r, lat);
        end
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'h11223344 || r !== 2'b00 || lat !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_rd4: rdata=%h rresp=%b lat1=%b, required 11223344 00 1", d, r, lat);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        logic [1:0]  r;
        logic        lat;
        sel = 1'b0;
        sts = 64'hAAAA0001_BBBB0001;
        rd(32'h00, d, r, lat);
        n_cmp++;
        if (d !== 32'hBBBB0001) begin
            n_bad++;
            $display("FAIL snap_rd0: rdata=%h, required bbbb0001", d);
        end
        sts = 64'hCCCC0002_DDDD0002;
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'hAAAA0001 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL snap_rd4_coherent: rdata=%h rresp=%b, required aaaa0001 00", d, r);
        end
        sel = 1'b1;
        sts = 64'hAAAA0001_BBBB0001;
        rd(32'h00, d, r, lat);
        n_cmp++;
        if (d !== 32'hBBBB0001) begin
            n_bad++;
            $display("FAIL live_rd0: rdata=%h, required bbbb0001", d);
        end
        sts = 64'hCCCC0002_DDDD0002;
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'hCCCC0002 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL live_rd4: rdata=%h rresp=%b, required cccc0002 00", d, r);
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        logic ok;
        sel = 1'b0;
        @(negedge aclk);
        araddr = 32'h04;
        arvalid = 1'b1;
        wait_arready(ok);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        araddr = 32'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            n_cmp++;
            if (m_rvalid !== 1'b1 || m_rdata !== 32'hAAAA0001 || m_arready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: rvalid=%b rdata=%h arready=%b, required 1 aaaa0001 0",
                         i, m_rvalid, m_rdata, m_arready);
            end
        end
        rready = 1'b1;
        @(posedge aclk);
        #1;
        rready = 1'b0;
        n_cmp++;
        if (m_rvalid !== 1'b0 || m_arready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: rvalid=%b arready=%b, required 0 1", m_rvalid, m_arready);
        end
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        n_cmp++;
        if (m_rvalid !== 1'b1 || m_rdata !== 32'hDDDD0002 || m_rresp !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_second_rd: rvalid=%b rdata=%h rresp=%b, required 1 dddd0002 00",
                     m_rvalid, m_rdata, m_rresp);
        end
        rready = 1'b1;
        @(posedge aclk);
        #1;
        rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        logic        lat;
        sel = 1'b0;
        sts = 64'h12345678_9ABCDEF0;
        rd(32'h08, d, r, lat);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10 || lat !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_rd8: rdata=%h rresp=%b lat1=%b, required 00000000 10 1", d, r, lat);
        end
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'hCCCC0002 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL oor_snapshot_kept: rdata=%h rresp=%b, required cccc0002 00", d, r);
        end
    endtask

    task automatic test_write();
        logic [31:0] d;
        logic [1:0]  r;
        logic        lat;
        bcnt = 0;
        blast = 2'b00;
        bready = 1'b1;
        @(negedge aclk);
        wdata = 32'hDEADBEEF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bcnt !== 0) begin
            n_bad++;
            $display("FAIL wr_no_early_b: bvalid cycles=%0d, required 0", bcnt);
        end
        awaddr = 32'h0;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (bcnt !== 1 || blast !== 2'b10) begin
            n_bad++;
            $display("FAIL wr_w_first: bvalid cycles=%0d bresp=%b, required 1 10", bcnt, blast);
        end
        bcnt = 0;
        blast = 2'b00;
        awvalid = 1'b1;
        wvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (bcnt !== 1 || blast !== 2'b10) begin
            n_bad++;
            $display("FAIL wr_same_cycle: bvalid cycles=%0d bresp=%b, required 1 10", bcnt, blast);
        end
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'hCCCC0002 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_read_unchanged: rdata=%h rresp=%b, required cccc0002 00", d, r);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic [1:0]  r;
        logic        lat;
        logic        ok;
        sel = 1'b0;
        sts = 64'h0BAD0BAD_0F0F0F0F;
        @(negedge aclk);
        araddr = 32'h00;
        arvalid = 1'b1;
        wait_arready(ok);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        n_cmp++;
        if (m_rvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_rvalid: rvalid=%b, required 1", m_rvalid);
        end
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if (m_rvalid !== 1'b0 || m_arready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async_drop: rvalid=%b arready=%b, required 0 0", m_rvalid, m_arready);
        end
        @(negedge aclk);
        areset = 1'b0;
        rd(32'h04, d, r, lat);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_snapshot_cleared: rdata=%h rresp=%b, required 00000000 00", d, r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_snapshot();
        test_backpressure();
        test_out_of_range();
        test_write();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
